accumulator_fixed_point_16_bit: RTL and testbench

Downstream stage of the 16-bit fixed-point multiplier. It sums a stream of LEN signed Q(12,16) products plus a bias into one neuron pre-activation for the VAE layer datapath. It uses a guard-bit accumulator, saturates the result back to 16 bits, and propagates a sticky overflow flag. Valid/ready handshakes are used on both input and output.

---
 rtl/accumulator_fixed_point_16_bit.sv | 123 ++++++++++++
 tb/tb_accumulator_fixed_point_16_bit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/accumulator_fixed_point_16_bit.sv
// Sums LEN signed Q12 products plus a bias in a guard-bit accumulator, then
// saturates the result to N bits with a sticky overflow flag.
module accumulator_fixed_point_16_bit #(
  parameter int Q     = 12,
  parameter int N     = 16,
  parameter int LEN   = 16,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_ovf,
  input  logic [N-1:0] bias,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf,
  output logic         busy
);

  localparam int AW = N + GUARD;
  localparam int CW = $clog2(LEN + 1);
  localparam logic [AW-1:0] MAX_S = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic [AW-1:0] MIN_S = {{(GUARD + 1){1'b1}}, {(N - 1){1'b0}}};

  if (Q >= N || LEN < 1 || (LEN + 1) > (2 ** GUARD)) begin : g_param_check
    $error("accumulator_fixed_point_16_bit: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            ovf_sticky_r;
  logic [AW-1:0]   sum_s;
  logic            ovf_next_s;
  logic            last_s;
  logic [N:0]      sat_s;

  // Clamp a full-width sum to N bits; MSB of the result is the saturation flag.
  function automatic logic [N:0] saturate(input logic [AW-1:0] s);
    if ($signed(s) > $signed(MAX_S)) begin
      saturate = {1'b1, 1'b0, {(N - 1){1'b1}}};
    end else if ($signed(s) < $signed(MIN_S)) begin
      saturate = {1'b1, 1'b1, {(N - 1){1'b0}}};
    end else begin
      saturate = {1'b0, s[N-1:0]};
    end
  endfunction

  assign in_ready = rst_n && (state_r != OUTPUT);

  // Next accumulator value, sticky flag and last-beat detect for the current state.
  always_comb begin
    sum_s      = acc_r + {{GUARD{in_data[N-1]}}, in_data};
    ovf_next_s = ovf_sticky_r | in_ovf;
    last_s     = (cnt_r == CW'(LEN - 1));
    if (state_r == IDLE) begin
      sum_s      = {{GUARD{bias[N-1]}}, bias} + {{GUARD{in_data[N-1]}}, in_data};
      ovf_next_s = in_ovf;
      last_s     = (LEN == 1);
    end else begin
      sum_s      = acc_r + {{GUARD{in_data[N-1]}}, in_data};
    end
    sat_s = saturate(sum_s);
  end

  // Handshake FSM, accumulator and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      acc_r        <= {AW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      ovf_sticky_r <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= {N{1'b0}};
      out_ovf      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc_r        <= sum_s;
            cnt_r        <= (state_r == IDLE) ? CW'(1) : cnt_r + CW'(1);
            ovf_sticky_r <= ovf_next_s;
            busy         <= 1'b1;
            if (last_s) begin
              state_r   <= OUTPUT;
              out_data  <= sat_s[N-1:0];
              out_ovf   <= ovf_next_s | sat_s[N];
              out_valid <= 1'b1;
            end else begin
              state_r <= ACCUM;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_r      <= IDLE;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            acc_r        <= {AW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            ovf_sticky_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_fixed_point_16_bit.sv
// Directed test of the fixed-point accumulator with LEN=4 and hand-computed results.
module tb_accumulator_fixed_point_16_bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_ovf = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  accumulator_fixed_point_16_bit #(.Q(12), .N(16), .LEN(4), .GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ovf(in_ovf), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Four back-to-back beats with out_ready=1, then check result and one-cycle valid.
  task automatic run_result(input string tag, input logic [15:0] b, input logic [63:0] d,
                            input logic [3:0] ov, input logic [15:0] exp_data,
                            input logic exp_ovf);
    out_ready = 1'b1;
    bias = b;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[16*i +: 16];
      in_ovf   = ov[i];
      chk1({tag, " in_ready"}, in_ready, 1'b1);
      tick();
      chk1({tag, " out_valid"}, out_valid, (i == 3));
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    chk16({tag, " out_data"}, out_data, exp_data);
    chk1({tag, " out_ovf"}, out_ovf, exp_ovf);
    tick();
    chk1({tag, " valid_drop"}, out_valid, 1'b0);
    chk1({tag, " busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [6:0] pat;

    // Reset state
    chk1("reset in_ready", in_ready, 1'b0);
    tick();
    tick();
    chk1("reset out_valid", out_valid, 1'b0);
    chk16("reset out_data", out_data, 16'h0000);
    chk1("reset out_ovf", out_ovf, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset in_ready2", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("idle in_ready", in_ready, 1'b1);

    // Basic sums and saturation boundaries
    run_result("basic", 16'h0000, {4{16'h1000}}, 4'b0000, 16'h4000, 1'b0);
    run_result("sat_pos", 16'h7000, {4{16'h1000}}, 4'b0000, 16'h7FFF, 1'b1);
    run_result("edge_neg", 16'hC000, {4{16'hF000}}, 4'b0000, 16'h8000, 1'b0);
    run_result("sat_neg", 16'hC000, {16'hEFFF, 16'hF000, 16'hF000, 16'hF000}, 4'b0000,
               16'h8000, 1'b1);
    run_result("edge_pos", 16'h3FFF, {4{16'h1000}}, 4'b0000, 16'h7FFF, 1'b0);

    // Sticky overflow and its clearing on the next result
    run_result("ovf_in", 16'h0000, {4{16'h0200}}, 4'b0010, 16'h0800, 1'b1);
    run_result("ovf_clr", 16'h0000, {4{16'h0200}}, 4'b0000, 16'h0800, 1'b0);

    // Backpressure: result held, incoming beats refused
    out_ready = 1'b0;
    bias = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100;
      tick();
    end
    chk1("bp busy_accum", busy, 1'b1);
    in_data = 16'h7000;
    for (int i = 0; i < 5; i++) begin
      chk1("bp in_ready", in_ready, 1'b0);
      tick();
      chk1("bp out_valid", out_valid, 1'b1);
      chk16("bp out_data", out_data, 16'h0400);
      chk1("bp busy", busy, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk1("bp release valid", out_valid, 1'b0);
    chk1("bp release busy", busy, 1'b0);
    chk16("bp data held", out_data, 16'h0400);
    run_result("bp fresh", 16'h0000, {4{16'h0080}}, 4'b0000, 16'h0200, 1'b0);

    // Bubbles in the input stream are not counted
    bias    = 16'h0100;
    in_data = 16'h0100;
    pat     = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      tick();
      chk1("bubble out_valid", out_valid, (i == 6));
    end
    in_valid = 1'b0;
    chk16("bubble out_data", out_data, 16'h0500);
    chk1("bubble out_ovf", out_ovf, 1'b0);
    tick();

    // Reset mid-accumulation discards the partial sum
    bias = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h2000;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk1("mid-reset in_ready", in_ready, 1'b0);
    tick();
    chk1("mid-reset out_valid", out_valid, 1'b0);
    chk16("mid-reset out_data", out_data, 16'h0000);
    chk1("mid-reset busy", busy, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    run_result("post-reset", 16'h0000, {4{16'h0100}}, 4'b0000, 16'h0400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
